// File: rtl/pe_psum_acc_if.sv
// Job/beat/result handshake bundle for the PE partial-sum accumulator.
// Protocol: a transfer happens on a rising edge where valid & ready are both 1; once raised, valid and data hold until that transfer.
interface pe_psum_acc_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             ovf;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf, busy
  );
endinterface

// File: rtl/pe_psum_acc.sv
// Accumulates a job of LEN signed 32-bit add-tree beats into one partial sum with a sticky per-job overflow flag.
// Optional feature macro PE_PSUM_SAT_EN: saturate on signed overflow instead of wrapping modulo 2^32.
module pe_psum_acc #(
  parameter int LEN_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_psum_acc_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [31:0]      sum;
  logic [31:0]      sum_nxt;
  logic             ovf_q;
  logic             ovf_nxt;

  logic [32:0]      sum_ext;
  logic             add_ovf;
  logic [31:0]      add_res;

  // One extra sign bit makes the exact signed result visible; overflow is when the top two bits disagree.
  assign sum_ext = {sum[31], sum} + {bus.in_data[31], bus.in_data};
  assign add_ovf = sum_ext[32] ^ sum_ext[31];

`ifdef PE_PSUM_SAT_EN
  assign add_res = add_ovf ? (sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                           : sum_ext[31:0];
`else
  assign add_res = sum_ext[31:0];
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sum_nxt   = sum;
    ovf_nxt   = ovf_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          cnt_nxt   = bus.len;
          sum_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = (bus.len == '0) ? OUT : ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          sum_nxt = add_res;
          ovf_nxt = ovf_q | add_ovf;
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state_nxt = OUT;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sum   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sum   <= sum_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  // The sum register doubles as the result: it holds after the job until the next accepted start clears it.
  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = sum;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: doc/pe_psum_acc.md
PE_PSUM_ACC -- requirements
Module: pe_psum_acc

Interface
REQ-001 Parameter LEN_W, default 8: width of the job beat-count field.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  job start pulse; sampled only in IDLE.
REQ-005 len  input  LEN_W  beats in job; latched with start.
REQ-006 in_valid  input  1  upstream add-tree sum valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  32  signed add-tree sum (one beat).
REQ-009 out_valid  output  1  final partial sum valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_data  output  32  signed accumulated sum.
REQ-012 ovf  output  1  signed overflow occurred during current/last job (sticky per job).
REQ-013 busy  output  1  high in any state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACC, OUT.
REQ-015 IDLE: start=1 -> latch len into beat counter, clear sum and ovf; next state ACC if len!=0, OUT if len==0 (result 0).
REQ-016 start SHALL be ignored in ACC and OUT; len SHALL be sampled only with accepted start.
REQ-017 in_ready SHALL be 1 only in ACC; beat accepted when in_valid & in_ready.
REQ-018 Each accepted beat: sum <= sum + in_data (32-bit signed), counter decrements.
REQ-019 Accepting the beat that brings the counter to 0 SHALL move ACC -> OUT; out_valid high the next cycle with the final sum (1-cycle latency after last beat).
REQ-020 in_valid low in ACC SHALL stall without state change; there is no timeout.
REQ-021 OUT: out_valid=1, out_data held stable until out_valid & out_ready; then -> IDLE the next cycle.
REQ-022 start asserted in the out-handshake cycle SHALL be ignored; start is accepted from the following IDLE cycle.
REQ-023 out_data SHALL hold the last result after returning to IDLE until the next accepted start clears it.
REQ-024 ovf SHALL be set when an addition's exact signed result is outside [-2^31, 2^31-1]; it stays set until next accepted start.
REQ-025 len = 2^LEN_W-1 (255) SHALL be supported; counter never wraps.

Reset
REQ-026 rst_n=0 at a clock edge: state IDLE, sum=0, counter=0, ovf=0; outputs in_ready=0, out_valid=0, out_data=0, ovf=0, busy=0.
REQ-027 Reset mid-job (ACC or OUT) SHALL abandon the job; pending result is discarded and not presented.

Configuration
REQ-028 Macro PE_PSUM_SAT_EN defined: on overflow, sum SHALL saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative) and later beats continue from the saturated value; ovf set.
REQ-029 Macro undefined: sum wraps modulo 2^32; ovf still reports overflow.

Verification
REQ-030 start, len=3, beats 10, -4, 100 with in_valid constant, out_ready=1 -> out_valid one cycle after third beat, out_data=106, ovf=0, busy low the cycle after.
REQ-031 start, len=0 -> no in_ready, next cycle out_valid=1, out_data=0.
REQ-032 len=2, beats 0x7FFFFFFF, 1 -> with PE_PSUM_SAT_EN out_data=0x7FFFFFFF, without out_data=0x80000000; ovf=1 in both.
REQ-033 len=4, in_valid toggling 1-0-1-0..., out_ready held 0 for 5 cycles -> only 4 beats summed, out_data stable, out_valid held until out_ready=1.
REQ-034 Reset pulsed after 2 of 4 beats, then start len=1, beat 7 -> out_data=7, no stale result observed.
REQ-035 start pulsed in ACC and in handshake cycle -> ignored; len change mid-job has no effect.
